trapez_energy_extractor: RTL and testbench
==========================================

// Module: trapez_energy_extractor
// PURPOSE
//  Consumer of the trapez_shaper output stream (output_data/output_data_valid).
//  Detects each trapezoid, skips the rise, averages FLAT_SAMPLES flat-top samples
//  and delivers one signed energy word per pulse over a valid/ready handshake.
//  Sits between trapez_shaper and the spectrum/histogram stage.
// PARAMETERS
//  DATA_WIDTH   16   width of signed shaper samples and of energy
//  RISE_DELAY   32   valid samples skipped after trigger before flat-top averaging
//  FLAT_LOG2    3    log2 of flat-top samples averaged (FLAT_SAMPLES = 2**FLAT_LOG2)
//  HOLDOFF      64   valid samples ignored after each pulse (result or abort)
//  CNT_WIDTH    8    width of dropped_count / aborted_count
// PORTS
//  clk               in   1           system clock, all logic on rising edge
//  reset             in   1           asynchronous, active-high reset
//  input_data        in   DATA_WIDTH  signed shaper sample (from trapez_shaper output_data)
//  input_data_valid  in   1           sample qualifier (from trapez_shaper output_data_valid)
//  threshold         in   DATA_WIDTH  signed trigger/flat-top threshold, static during run
//  energy            out  DATA_WIDTH  signed averaged flat-top amplitude
//  energy_valid      out  1           energy holds a result not yet accepted
//  energy_ready      in   1           downstream accepts energy when high with energy_valid
//  busy              out  1           FSM not in IDLE
//  dropped_count     out  CNT_WIDTH   results lost to backpressure, saturating
//  aborted_count     out  CNT_WIDTH   pulses aborted in flat-top, saturating
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters/accumulator 0; reset mid-pulse discards it.
//  Only cycles with input_data_valid=1 advance counters or accumulate; invalid cycles stall.
//  FSM:
//   IDLE    : valid sample with input_data > threshold (signed, strict) -> DELAY, cnt=0.
//             Trigger sample is not counted in the delay.
//   DELAY   : count RISE_DELAY valid samples; on the RISE_DELAY-th -> ACCUM, acc=0, cnt=0.
//   ACCUM   : each valid sample: if input_data > threshold, acc += sign-extended sample;
//             else abort: aborted_count++ (sat), -> HOLD.
//             On the FLAT_SAMPLES-th accepted sample -> result = (acc+sample) >>> FLAT_LOG2,
//             -> HOLD.
//   HOLD    : count HOLDOFF valid samples, then -> IDLE (re-arm; no retrigger while HOLD).
//  Accumulator width DATA_WIDTH+FLAT_LOG2 signed, never overflows; arithmetic right shift,
//  rounding toward -inf; result always fits DATA_WIDTH.
//  Latency: energy/energy_valid update on the edge after the edge sampling the last
//  flat-top sample (registered output, 1 cycle).
//  Handshake: energy/energy_valid stable while energy_valid=1 and energy_ready=0.
//   Transfer on any edge with energy_valid=1 and energy_ready=1.
//   New result with register empty, or full and transferring same edge: load, valid stays 1.
//   New result with register full and no transfer: new result discarded,
//   dropped_count++ (saturates at 2**CNT_WIDTH-1), held result untouched.
//  busy=1 in DELAY/ACCUM/HOLD; energy_valid independent of FSM state.
// TESTING (DATA_WIDTH=16, RISE_DELAY=4, FLAT_LOG2=3, HOLDOFF=10, threshold=100, ready=1)
//  1 Basic: 5x0, 150,300,600,900, 12x1000, zeros -> one energy=1000, 1 cycle after 8th
//    flat sample; dropped/aborted=0.
//  2 Averaging: after delay feed 1000..1007 -> energy=1003 (8028>>>3); flat of -50 below
//    threshold never triggers; -2000 input idle -> no output.
//  3 Abort: pulse as test 1 but 4th flat sample=50 -> no energy_valid, aborted_count=1;
//    next pulse after HOLDOFF measured normally (energy=1000).
//  4 Backpressure: ready=0, two test-1 pulses -> energy=1000 held, second dropped,
//    dropped_count=1; repeat with ready pulsed on result edge -> no drop, second loads.
//  5 Stall: test 1 with input_data_valid toggling every cycle (invalid carry garbage 30000)
//    -> energy=1000, latency doubled, garbage ignored.
//  6 Reset: assert reset during ACCUM -> outputs/counters 0 immediately, busy=0;
//    next pulse yields energy=1000.

Source files
------------

// File: rtl/trapez_energy_extractor.sv
// trapez_energy_extractor
//   Consumes the trapezoidal shaper sample stream, detects each pulse, skips
//   the rising edge, averages 2**FLAT_LOG2 flat-top samples and hands one
//   signed energy word per pulse downstream over a valid/ready handshake.
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   input_data        : signed shaper sample
//   input_data_valid  : sample qualifier; invalid cycles stall all counting
//   threshold         : signed trigger / flat-top threshold (static in a run)
//   energy            : signed averaged flat-top amplitude
//   energy_valid      : energy holds a result not yet accepted
//   energy_ready      : downstream accept
//   busy              : pulse processing in progress (not idle)
//   dropped_count     : results lost to backpressure (saturating)
//   aborted_count     : pulses that fell below threshold in flat-top (saturating)
module trapez_energy_extractor #(
  parameter int DATA_WIDTH = 16,
  parameter int RISE_DELAY = 32,
  parameter int FLAT_LOG2  = 3,
  parameter int HOLDOFF    = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] input_data,
  input  logic                         input_data_valid,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  output logic signed [DATA_WIDTH-1:0] energy,
  output logic                         energy_valid,
  input  logic                         energy_ready,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         dropped_count,
  output logic [CNT_WIDTH-1:0]         aborted_count
);

  localparam int FLAT_SAMPLES = 1 << FLAT_LOG2;
  localparam int ACC_W        = DATA_WIDTH + FLAT_LOG2;
  localparam int MAX_RD       = (RISE_DELAY > HOLDOFF) ? RISE_DELAY : HOLDOFF;
  localparam int MAXC         = (MAX_RD > FLAT_SAMPLES) ? MAX_RD : FLAT_SAMPLES;
  localparam int CW           = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RISE_LAST = CW'(RISE_DELAY - 1);
  localparam logic [CW-1:0] FLAT_LAST = CW'(FLAT_SAMPLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF - 1);

  typedef enum logic [1:0] {IDLE, DELAY, ACCUM, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    above;
  logic [CNT_WIDTH-1:0]    aborted_nxt;
  logic                    res_vld_nxt;
  logic signed [DATA_WIDTH-1:0] res_nxt;
  logic signed [DATA_WIDTH-1:0] res_p0;
  logic                         vld_p0;

  // Divide by the power-of-two sample count, rounding toward -inf.
  // The sum of FLAT_SAMPLES in-range samples always fits after the shift.
  function automatic logic signed [DATA_WIDTH-1:0] avg_floor(
    input logic signed [ACC_W-1:0] s);
    return DATA_WIDTH'(s >>> FLAT_LOG2);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign sample_ext = {{FLAT_LOG2{input_data[DATA_WIDTH-1]}}, input_data};
  assign sum        = acc + sample_ext;
  assign above      = input_data > threshold;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    acc_nxt     = acc;
    aborted_nxt = aborted_count;
    res_vld_nxt = 1'b0;
    res_nxt     = res_p0;
    if (input_data_valid) begin
      case (state)
        IDLE: begin
          // The trigger sample itself is not part of the rise delay.
          if (above) begin
            state_nxt = DELAY;
            cnt_nxt   = '0;
          end
        end
        DELAY: begin
          if (cnt == RISE_LAST) begin
            state_nxt = ACCUM;
            cnt_nxt   = '0;
            acc_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ACCUM: begin
          if (!above) begin
            aborted_nxt = sat_inc(aborted_count);
            state_nxt   = HOLD;
            cnt_nxt     = '0;
          end else if (cnt == FLAT_LAST) begin
            res_nxt     = avg_floor(sum);
            res_vld_nxt = 1'b1;
            acc_nxt     = sum;
            state_nxt   = HOLD;
            cnt_nxt     = '0;
          end else begin
            acc_nxt = sum;
            cnt_nxt = cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p0: pulse FSM, accumulator and averaged result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      aborted_count <= '0;
      res_p0        <= '0;
      vld_p0        <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      acc           <= acc_nxt;
      aborted_count <= aborted_nxt;
      res_p0        <= res_nxt;
      vld_p0        <= res_vld_nxt;
    end
  end

  // Stage p1: output holding register with valid/ready handshake.
  // A new result only replaces the held one if it is empty or leaving now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      energy        <= '0;
      energy_valid  <= 1'b0;
      dropped_count <= '0;
    end else if (vld_p0) begin
      if (!energy_valid || energy_ready) begin
        energy       <= res_p0;
        energy_valid <= 1'b1;
      end else begin
        dropped_count <= sat_inc(dropped_count);
      end
    end else if (energy_valid && energy_ready) begin
      energy_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trapez_energy_extractor.sv
module tb_trapez_energy_extractor;

  localparam int R = 4;
  localparam int F = 8;
  localparam int H = 10;

  logic clk;
  logic rst;
  logic signed [15:0] din;
  logic dv;
  logic signed [15:0] thr_s;
  logic signed [15:0] energy;
  logic ev;
  logic rdy;
  logic busy;
  logic [7:0] dropped;
  logic [7:0] aborted;

  int thr;
  int n_checks = 0;
  int n_fail = 0;
  int n_seen;
  int e_seen;

  assign thr_s = 16'(thr);

  trapez_energy_extractor #(
    .DATA_WIDTH(16), .RISE_DELAY(R), .FLAT_LOG2(3), .HOLDOFF(H), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(rst), .input_data(din), .input_data_valid(dv),
    .threshold(thr_s), .energy(energy), .energy_valid(ev), .energy_ready(rdy),
    .busy(busy), .dropped_count(dropped), .aborted_count(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pulse position counted in valid samples since trigger.
  int m_pos, m_rel, m_sum, m_pres, m_e, m_drop, m_ab;
  bit m_pend, m_ev;

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_pos = -1; m_rel = -1; m_sum = 0; m_pres = 0;
    m_e = 0; m_drop = 0; m_ab = 0; m_pend = 0; m_ev = 0;
  endtask

  task automatic model_step(input int d, input bit v, input bit r);
    bit xfer;
    xfer = m_ev && r;
    if (m_pend) begin
      if (!m_ev || r) begin
        m_e = m_pres; m_ev = 1;
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end else if (xfer) begin
      m_ev = 0;
    end
    m_pend = 0;
    if (v) begin
      if (m_pos < 0) begin
        if (d > thr) begin m_pos = 0; m_rel = -1; m_sum = 0; end
      end else begin
        m_pos++;
        if (m_rel < 0) begin
          if (m_pos > R) begin
            if (d > thr) begin
              m_sum += d;
              if (m_pos == R + F) begin
                m_pend = 1; m_pres = fdiv(m_sum, F); m_rel = m_pos;
              end
            end else begin
              if (m_ab < 255) m_ab++;
              m_rel = m_pos;
            end
          end
        end else if (m_pos == m_rel + H) begin
          m_pos = -1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("energy_valid", int'(ev), int'(m_ev));
    chk("energy", int'(energy), m_e);
    chk("busy", int'(busy), int'(m_pos >= 0));
    chk("dropped_count", int'(dropped), m_drop);
    chk("aborted_count", int'(aborted), m_ab);
  endtask

  task automatic cyc(input int d, input bit v, input bit r);
    din = 16'(d); dv = v; rdy = r;
    @(posedge clk);
    model_step(d, v, r);
    #1;
    check_all();
    if (ev) begin n_seen++; e_seen = int'(energy); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Pulse: 5x0, 150,300,600,900, fv (last delay), 8 flat (ab_idx -> 50),
  // 3 more fv, then tail zeros. rmode 0/1 = fixed ready, 2 = ready on result edge.
  task automatic play(input int fv, input int ab_idx, input bit stall,
                      input int rmode, input int tail, input bit lat);
    int s[$];
    bit r;
    s = {0, 0, 0, 0, 0, 150, 300, 600, 900, fv};
    for (int k = 0; k < F; k++) s.push_back((k == ab_idx) ? 50 : fv);
    for (int k = 0; k < 3; k++) s.push_back(fv);
    for (int k = 0; k < tail; k++) s.push_back(0);
    for (int i = 0; i < s.size(); i++) begin
      r = (rmode == 2) ? m_pend : (rmode != 0);
      cyc(s[i], 1'b1, r);
      if (lat && i == 17) chk("latency_before", int'(ev), 0);
      if (lat && i == 18) begin
        chk("latency_valid", int'(ev), 1);
        chk("latency_energy", int'(energy), 1000);
      end
      if (stall) begin
        r = (rmode == 2) ? m_pend : (rmode != 0);
        cyc(30000, 1'b0, r);
      end
    end
  endtask

  typedef struct {
    int thr; int idle; int trig; int base; int step;
    int ovr_idx; int ovr_val; int exp_n; int exp_e; int exp_ab;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int v;
    rst = 1'b1; din = '0; dv = 1'b0; rdy = 1'b0; thr = 100;
    n_seen = 0; e_seen = 0;
    model_reset();

    vecs[0]  = '{100, 0, 150, 1000, 0, -1, 0, 1, 1000, 0};
    vecs[1]  = '{100, 0, 150, 1000, 1, -1, 0, 1, 1003, 0};
    vecs[2]  = '{100, 0, 150, 1000, 0, 3, 50, 0, 0, 1};
    vecs[3]  = '{100, 0, 150, 32767, 0, -1, 0, 1, 32767, 0};
    vecs[4]  = '{100, 0, 150, 101, 0, 0, 102, 1, 101, 0};
    vecs[5]  = '{100, 0, -50, -50, 0, -1, 0, 0, 0, 0};
    vecs[6]  = '{100, 0, -2000, -2000, 0, -1, 0, 0, 0, 0};
    vecs[7]  = '{100, 0, 100, 100, 0, -1, 0, 0, 0, 0};
    vecs[8]  = '{-1000, -32768, -500, -500, 0, 7, -499, 1, -500, 0};
    vecs[9]  = '{100, 0, 101, 1000, 0, 7, 100, 0, 0, 1};
    vecs[10] = '{-32768, -32768, -32767, -32767, 0, -1, 0, 1, -32767, 0};

    for (int i = 0; i < 11; i++) begin
      do_reset();
      thr = vecs[i].thr;
      n_seen = 0; e_seen = 0;
      repeat (5) cyc(vecs[i].idle, 1'b1, 1'b1);
      cyc(vecs[i].trig, 1'b1, 1'b1);
      for (int k = 1; k <= R; k++)
        cyc(vecs[i].trig + (vecs[i].base - vecs[i].trig) * k / R, 1'b1, 1'b1);
      for (int k = 0; k < F; k++) begin
        v = vecs[i].base + vecs[i].step * k;
        if (k == vecs[i].ovr_idx) v = vecs[i].ovr_val;
        cyc(v, 1'b1, 1'b1);
      end
      repeat (20) cyc(vecs[i].idle, 1'b1, 1'b1);
      chk($sformatf("row%0d_results", i), n_seen, vecs[i].exp_n);
      if (vecs[i].exp_n > 0) chk($sformatf("row%0d_energy", i), e_seen, vecs[i].exp_e);
      chk($sformatf("row%0d_aborted", i), int'(aborted), vecs[i].exp_ab);
    end

    // Basic pulse with explicit one-cycle result latency
    do_reset(); thr = 100; n_seen = 0;
    play(1000, -1, 1'b0, 1, 10, 1'b1);
    chk("basic_results", n_seen, 1);

    // Stalled stream with garbage on invalid cycles
    n_seen = 0; e_seen = 0;
    play(1000, -1, 1'b1, 1, 10, 1'b0);
    chk("stall_results", n_seen, 1);
    chk("stall_energy", e_seen, 1000);

    // Abort followed by a normal pulse after holdoff
    do_reset(); n_seen = 0; e_seen = 0;
    play(1000, 3, 1'b0, 1, 10, 1'b0);
    play(1000, -1, 1'b0, 1, 10, 1'b0);
    chk("abort_then_results", n_seen, 1);
    chk("abort_then_energy", e_seen, 1000);
    chk("abort_count", int'(aborted), 1);

    // Backpressure: held result untouched, second dropped
    do_reset();
    play(1000, -1, 1'b0, 0, 10, 1'b0);
    play(2000, -1, 1'b0, 0, 10, 1'b0);
    chk("bp_energy_held", int'(energy), 1000);
    chk("bp_valid_held", int'(ev), 1);
    chk("bp_dropped", int'(dropped), 1);
    cyc(0, 1'b1, 1'b1);
    play(1000, -1, 1'b0, 2, 10, 1'b0);
    play(2000, -1, 1'b0, 2, 10, 1'b0);
    chk("bp_ready_pulse_energy", int'(energy), 2000);
    chk("bp_ready_pulse_dropped", int'(dropped), 1);

    // Reset in the middle of flat-top accumulation
    play(1000, 3, 1'b0, 0, 10, 1'b0);
    cyc(0, 1'b1, 1'b0); cyc(150, 1'b1, 1'b0);
    repeat (R + 3) cyc(1000, 1'b1, 1'b0);
    chk("pre_reset_busy", int'(busy), 1);
    do_reset();
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(ev), 0);
    n_seen = 0; e_seen = 0;
    play(1000, -1, 1'b0, 1, 10, 1'b0);
    chk("post_reset_energy", e_seen, 1000);

    // Counter saturation
    do_reset();
    repeat (260) play(1000, -1, 1'b0, 0, 10, 1'b0);
    chk("dropped_saturated", int'(dropped), 255);
    repeat (260) play(1000, 3, 1'b0, 0, 10, 1'b0);
    chk("aborted_saturated", int'(aborted), 255);

    // Randomized stream against the model
    do_reset(); thr = 100;
    for (int i = 0; i < 3000; i++) begin
      bit rv, rr;
      int rd;
      rv = ($urandom_range(0, 3) != 0);
      rr = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) rd = int'($urandom_range(0, 200)) - 100;
      else rd = int'($urandom_range(101, 4000));
      cyc(rd, rv, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
